// File: rtl/vote_scan_ctrl.sv
// vote_scan_ctrl: walks the voter decoder through every voter line, samples
// the shared sense return at the end of each voter's settle window, and
// publishes yes-count / vote mask / pass with a one-cycle done pulse.
module vote_scan_ctrl #(
    parameter int N_VOTERS = 8,
    parameter int SETTLE   = 2,
    parameter int THRESH   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sense,
    output logic [2:0] dec_d,
    output logic [2:0] dec_g,
    output logic       busy,
    output logic       done,
    output logic [3:0] yes_cnt,
    output logic [7:0] vote_mask,
    output logic       pass
);

    // One-hot so the decoder enable comes straight off a single flop bit.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SCAN = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t     state, state_nx;
    logic [2:0] idx;
    logic [3:0] settle;
    logic [3:0] acc_cnt;
    logic [7:0] acc_mask;
    logic [3:0] cnt_nx;
    logic [7:0] mask_nx;
    logic       last_settle;
    logic       last_voter;

    assign last_settle = (settle == 4'(SETTLE));
    assign last_voter  = (idx == 3'(N_VOTERS - 1));
    assign cnt_nx      = acc_cnt + {3'b000, sense};
    assign dec_d       = idx;

    // Accumulator value including the vote being captured this cycle.
    always_comb begin
        mask_nx      = acc_mask;
        mask_nx[idx] = sense;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and decoder/handshake outputs.
    always_comb begin
        state_nx = state;
        dec_g    = 3'b000;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = SCAN;
            end
            SCAN: begin
                dec_g = 3'b100;
                busy  = 1'b1;
                if (last_settle && last_voter) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Voter index, settle timer, accumulators and published results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            settle    <= '0;
            acc_cnt   <= '0;
            acc_mask  <= '0;
            yes_cnt   <= '0;
            vote_mask <= '0;
            pass      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        settle   <= '0;
                        acc_cnt  <= '0;
                        acc_mask <= '0;
                    end
                end
                SCAN: begin
                    if (last_settle) begin
                        settle   <= '0;
                        acc_cnt  <= cnt_nx;
                        acc_mask <= mask_nx;
                        if (last_voter) begin
                            // Results only move here, so they hold through the next scan.
                            yes_cnt   <= cnt_nx;
                            vote_mask <= mask_nx;
                            pass      <= (cnt_nx >= 4'(THRESH));
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        settle <= settle + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_scan_ctrl.sv
// Bench for vote_scan_ctrl: two instances (default parameters and a small
// N=3/SETTLE=0/THRESH=2 corner), a cycle-position model per instance that
// also plays the voters on the sense line, and a per-cycle compare process.
module tb_vote_scan_ctrl;

    logic clk = 1'b0;
    bit   clk_en = 1'b0;
    logic rst = 1'b1;

    logic [1:0]      start_v = 2'b00;
    logic [1:0]      sense_v;
    logic [1:0][2:0] dd, dg;
    logic [1:0]      busy_v, done_v, pass_v;
    logic [1:0][3:0] cnt_v;
    logic [1:0][7:0] mask_v;

    int NV[2] = '{8, 3};
    int SV[2] = '{2, 0};
    int TV[2] = '{5, 2};

    logic [7:0] ballot[2] = '{8'h00, 8'h00};
    bit         inv[2]    = '{1'b0, 1'b0};

    // model: m_c = cycle position inside current scan (0 = idle)
    int         m_c[2]    = '{0, 0};
    logic [3:0] e_cnt[2]  = '{4'd0, 4'd0};
    logic [7:0] e_mask[2] = '{8'h00, 8'h00};
    bit         e_pass[2] = '{1'b0, 1'b0};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 if (clk_en) clk = ~clk;

    vote_scan_ctrl u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sense(sense_v[0]),
        .dec_d(dd[0]), .dec_g(dg[0]), .busy(busy_v[0]), .done(done_v[0]),
        .yes_cnt(cnt_v[0]), .vote_mask(mask_v[0]), .pass(pass_v[0])
    );

    vote_scan_ctrl #(.N_VOTERS(3), .SETTLE(0), .THRESH(2)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sense(sense_v[1]),
        .dec_d(dd[1]), .dec_g(dg[1]), .busy(busy_v[1]), .done(done_v[1]),
        .yes_cnt(cnt_v[1]), .vote_mask(mask_v[1]), .pass(pass_v[1])
    );

    // Voter behaviour: the selected voter shows its ballot bit only in the
    // final settle cycle; earlier cycles optionally show the opposite value
    // so sampling at the wrong cycle is visible.
    function automatic logic exp_sense(int c, logic [7:0] b, bit iv, int n, int s);
        if (c < 1 || c > n * (s + 1)) return 1'b0;
        return b[(c - 1) / (s + 1)] ^ (iv && (((c - 1) % (s + 1)) != s));
    endfunction

    assign sense_v[0] = exp_sense(m_c[0], ballot[0], inv[0], NV[0], SV[0]);
    assign sense_v[1] = exp_sense(m_c[1], ballot[1], inv[1], NV[1], SV[1]);

    function automatic logic [7:0] vmask(int n);
        return 8'((1 << n) - 1);
    endfunction

    // model: position counter per instance; results come from the ballot
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_c[k]    <= 0;
                e_cnt[k]  <= 4'd0;
                e_mask[k] <= 8'h00;
                e_pass[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_c[k] == 0) begin
                    if (start_v[k]) m_c[k] <= 1;
                end else if (m_c[k] == NV[k] * (SV[k] + 1) + 1) begin
                    m_c[k] <= 0;
                end else begin
                    m_c[k] <= m_c[k] + 1;
                    if (m_c[k] == NV[k] * (SV[k] + 1)) begin
                        e_mask[k] <= ballot[k] & vmask(NV[k]);
                        e_cnt[k]  <= 4'($countones(ballot[k] & vmask(NV[k])));
                        e_pass[k] <= $countones(ballot[k] & vmask(NV[k])) >= TV[k];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                bit scan, dn;
                scan = (m_c[k] >= 1) && (m_c[k] <= NV[k] * (SV[k] + 1));
                dn   = (m_c[k] == NV[k] * (SV[k] + 1) + 1);
                chk($sformatf("u%0d {dec_g,busy,done,cnt,mask,pass}", k),
                    32'({dg[k], busy_v[k], done_v[k], cnt_v[k], mask_v[k], pass_v[k]}),
                    32'({(scan ? 3'b100 : 3'b000), scan | dn, dn, e_cnt[k], e_mask[k], e_pass[k]}));
                if (scan)
                    chk($sformatf("u%0d dec_d", k), 32'(dd[k]), 32'((m_c[k] - 1) / (SV[k] + 1)));
            end
        end
    end

    // Start a scan from a negedge in IDLE, wait for done, check results by
    // literal, then step one more cycle (busy must be low there).
    task automatic scan(input int k, input logic [7:0] b, input bit iv, input int exp_cyc,
                        input logic [3:0] ecnt, input logic [7:0] emask, input bit epass);
        int cyc;
        ballot[k]  = b;
        inv[k]     = iv;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        cyc = 1;
        while (!done_v[k] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("u%0d done cycle", k), 32'(cyc), 32'(exp_cyc));
        chk($sformatf("u%0d yes_cnt", k), 32'(cnt_v[k]), 32'(ecnt));
        chk($sformatf("u%0d vote_mask", k), 32'(mask_v[k]), 32'(emask));
        chk($sformatf("u%0d pass", k), 32'(pass_v[k]), 32'(epass));
        @(negedge clk);
        chk($sformatf("u%0d busy after done", k), 32'(busy_v[k]), 32'd0);
    endtask

    initial begin
        int ndone, d1, d2;

        // 1. reset with clock stopped
        #3;
        chk("u0 reset outputs", 32'({dd[0], dg[0], busy_v[0], done_v[0], cnt_v[0], mask_v[0], pass_v[0]}), 32'd0);
        chk("u1 reset outputs", 32'({dd[1], dg[1], busy_v[1], done_v[1], cnt_v[1], mask_v[1], pass_v[1]}), 32'd0);
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("u0 idle dec_g", 32'(dg[0]), 32'd0);

        // 2. all yes, sense steady
        scan(0, 8'hFF, 1'b0, 25, 4'd8, 8'hFF, 1'b1);

        // 3. mixed votes, then one more yes crosses the threshold
        scan(0, 8'b1011_0100, 1'b1, 25, 4'd4, 8'b1011_0100, 1'b0);
        scan(0, 8'b1011_0101, 1'b1, 25, 4'd5, 8'b1011_0101, 1'b1);

        // 4. start while busy is ignored; start in the IDLE cycle after done is taken
        ballot[0]  = 8'h3C;
        inv[0]     = 1'b1;
        start_v[0] = 1'b1;
        ndone = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            if (done_v[0]) begin
                ndone++;
                if (ndone == 1) d1 = c;
                else            d2 = c;
            end
            start_v[0] = (c == 5 || c == 25 || c == 26);
        end
        chk("ignored start: done count", 32'(ndone), 32'd2);
        chk("ignored start: first done", 32'(d1), 32'd25);
        chk("ignored start: second done", 32'(d2), 32'd51);
        chk("ignored start: yes_cnt", 32'(cnt_v[0]), 32'd4);

        // 5. asynchronous abort mid-cycle 10
        ballot[0]  = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort dec_g", 32'(dg[0]), 32'd0);
        chk("abort busy", 32'(busy_v[0]), 32'd0);
        chk("abort yes_cnt", 32'(cnt_v[0]), 32'd0);
        #1 rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        chk("abort: no done", 32'(ndone), 32'd0);
        scan(0, 8'b0101_1010, 1'b1, 25, 4'd4, 8'b0101_1010, 1'b0);

        // 6. small-parameter instance
        scan(1, 8'b0000_0101, 1'b0, 4, 4'd2, 8'b0000_0101, 1'b1);
        scan(1, 8'b0000_0010, 1'b0, 4, 4'd1, 8'b0000_0010, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
